// File: rtl/stac_scan_driver.sv
// stac_scan_driver: tester-side TAP sequencer that walks the STAC wrapper through one
// IR or DR scan per accepted command, drives TMS/WSI and captures WSO LSB-first.
// Optional feature: define STAC_DRV_TLR_INIT_EN to run a 5x TMS=1 / 1x TMS=0 TAP reset
// sequence after TRESETN deasserts; without it the driver comes out of reset idle.
module stac_scan_driver #(
    parameter int MAX_LEN = 33,
    parameter int LEN_W   = 6
) (
    input  logic               TCLK,
    input  logic               TRESETN,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_ir,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               TMS,
    output logic               WSI,
    input  logic               WSO
);
    typedef enum logic [3:0] {INIT, IDLE, SEL_IR, SEL, CAPTURE, SHIFT, EXIT1, UPDATE, DONE} state_t;

`ifdef STAC_DRV_TLR_INIT_EN
    localparam state_t RST_STATE = INIT;
    localparam logic   RST_TMS   = 1'b1;
`else
    localparam state_t RST_STATE = IDLE;
    localparam logic   RST_TMS   = 1'b0;
`endif

    state_t             state_q;
    logic               tms_q, wsi_q, rsp_valid_q;
    logic [MAX_LEN-1:0] data_q, rsp_data_q;
    logic [LEN_W-1:0]   len_q, cnt_q, len_d, cnt_d;
    logic               sample_d;

    // Clamp the requested length, step the cycle counter, and flag cycles whose WSO bit is kept.
    // SHIFT with cnt_q == 0 is the TMS=0 cycle that moves the TAP into Shift; it carries no data.
    always_comb begin
        len_d    = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
        cnt_d    = cnt_q + LEN_W'(1);
        sample_d = (state_q == SHIFT && cnt_q != '0) || state_q == EXIT1;
    end

    // Scan sequencer: each edge decides the registered TMS/WSI/rsp_valid for the coming cycle.
    always_ff @(posedge TCLK or negedge TRESETN) begin
        if (!TRESETN) begin
            state_q     <= RST_STATE;
            tms_q       <= RST_TMS;
            wsi_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            data_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
        end else begin
            tms_q       <= 1'b0;
            wsi_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            case (state_q)
                INIT: begin
                    cnt_q <= cnt_d;
                    tms_q <= cnt_q < LEN_W'(4);
                    if (cnt_q == LEN_W'(5)) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                IDLE: begin
                    if (cmd_valid) begin
                        data_q     <= cmd_data;
                        len_q      <= len_d;
                        cnt_q      <= '0;
                        rsp_data_q <= '0;
                        if (len_d == '0) begin
                            state_q     <= DONE;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q <= cmd_ir ? SEL_IR : SEL;
                            tms_q   <= 1'b1;
                        end
                    end
                end
                SEL_IR: begin
                    state_q <= SEL;
                    tms_q   <= 1'b1;
                end
                SEL:     state_q <= CAPTURE;
                CAPTURE: state_q <= SHIFT;
                SHIFT: begin
                    wsi_q  <= data_q[0];
                    data_q <= data_q >> 1;
                    cnt_q  <= cnt_d;
                    if (cnt_d == len_q) begin
                        state_q <= EXIT1;
                        tms_q   <= 1'b1;
                    end
                end
                EXIT1: begin
                    state_q <= UPDATE;
                    tms_q   <= 1'b1;
                end
                UPDATE: begin
                    state_q     <= DONE;
                    rsp_valid_q <= 1'b1;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (sample_d)
                rsp_data_q[cnt_q - LEN_W'(1)] <= WSO;
        end
    end

    assign cmd_ready = state_q == IDLE;
    assign TMS       = tms_q;
    assign WSI       = wsi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_stac_scan_driver.sv
// tb_stac_scan_driver: drives stac_scan_driver against a behavioural STAC TAP
// (8-bit IR, 33-bit DR, both capturing 0xCA) and checks against rule-based expectations.
module tb_stac_scan_driver;
    logic        TCLK = 1'b0, TRESETN = 1'b0, cmd_valid = 1'b0, cmd_ir = 1'b0;
    logic [5:0]  cmd_len = '0;
    logic [32:0] cmd_data = '0;
    logic        cmd_ready, rsp_valid, TMS, WSI, WSO;
    logic [32:0] rsp_data;

    int total = 0, bad = 0;

`ifdef STAC_DRV_TLR_INIT_EN
    localparam logic RST_TMS = 1'b1;
    localparam logic RST_RDY = 1'b0;
`else
    localparam logic RST_TMS = 1'b0;
    localparam logic RST_RDY = 1'b1;
`endif

    stac_scan_driver #(.MAX_LEN(33), .LEN_W(6)) dut (
        .TCLK(TCLK), .TRESETN(TRESETN), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .TMS(TMS), .WSI(WSI), .WSO(WSO)
    );

    always #5 TCLK = ~TCLK;

    // Behavioural IEEE 1149.1 TAP standing in for the STAC wrapper.
    localparam int TLR = 0, RTI = 1, SDR = 2, CDR = 3, SHDR = 4, E1DR = 5, PDR = 6, E2DR = 7, UDR = 8;
    localparam int SIR = 9, CIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14, UIR = 15;
    int          tap_s;
    logic [32:0] dr_sh, dr_upd;
    logic [7:0]  ir_sh, ir_upd;

    function automatic int nxt(int s, logic t);
        case (s)
            TLR:       return t ? TLR : RTI;
            RTI:       return t ? SDR : RTI;
            SDR:       return t ? SIR : CDR;
            CDR, SHDR: return t ? E1DR : SHDR;
            E1DR:      return t ? UDR : PDR;
            PDR:       return t ? E2DR : PDR;
            E2DR:      return t ? UDR : SHDR;
            UDR, UIR:  return t ? SDR : RTI;
            SIR:       return t ? TLR : CIR;
            CIR, SHIR: return t ? E1IR : SHIR;
            E1IR:      return t ? UIR : PIR;
            PIR:       return t ? E2IR : PIR;
            E2IR:      return t ? UIR : SHIR;
            default:   return TLR;
        endcase
    endfunction

    assign WSO = (tap_s == SHIR) ? ir_sh[0] : dr_sh[0];

    always @(posedge TCLK or negedge TRESETN) begin
        if (!TRESETN) begin
            tap_s  <= TLR;
            dr_sh  <= '0;
            dr_upd <= '0;
            ir_sh  <= '0;
            ir_upd <= '0;
        end else begin
            case (tap_s)
                CDR:  dr_sh  <= 33'h0CA;
                SHDR: dr_sh  <= {WSI, dr_sh[32:1]};
                UDR:  dr_upd <= dr_sh;
                CIR:  ir_sh  <= 8'hCA;
                SHIR: ir_sh  <= {WSI, ir_sh[7:1]};
                UIR:  ir_upd <= ir_sh;
                default: ;
            endcase
            tap_s <= nxt(tap_s, TMS);
        end
    end

    // Reference rules: cycle j counts from 1 at the cycle following acceptance.
    function automatic int eff(int len);
        return len > 33 ? 33 : len;
    endfunction

    function automatic int exp_n(bit ir, int L);
        return L == 0 ? 1 : L + (ir ? 6 : 5);
    endfunction

    function automatic bit exp_tms(bit ir, int L, int j);
        int p = ir ? 4 : 3;
        if (L == 0) return 1'b0;
        if (j == 1 || (ir && j == 2)) return 1'b1;
        return j == p + L || j == p + L + 1;
    endfunction

    function automatic bit exp_wsi(bit ir, int L, logic [32:0] d, int j);
        int p = ir ? 4 : 3;
        return (L > 0 && j > p && j <= p + L) ? d[j-p-1] : 1'b0;
    endfunction

    // Shifting L bits through a W-bit register: out come capture bits then data bits.
    function automatic logic [32:0] exp_rsp(bit ir, int L, logic [32:0] d);
        int w = ir ? 8 : 33;
        logic [127:0] full = (128'(d) << w) | 128'hCA;
        return L == 0 ? 33'd0 : 33'(full & ((128'd1 << L) - 128'd1));
    endfunction

    function automatic logic [32:0] exp_upd(bit ir, int L, logic [32:0] d, logic [32:0] old);
        int w = ir ? 8 : 33;
        logic [127:0] full = (128'(d) << w) | 128'hCA;
        return L == 0 ? old : 33'((full >> L) & ((128'd1 << w) - 128'd1));
    endfunction

    logic        tr_tms [0:63];
    logic        tr_wsi [0:63];
    logic        tr_rdy [0:63];
    int          n_cyc, rv_cnt, last_wait;
    logic [32:0] rsp_snap;

    // Issue one command and record TMS/WSI/cmd_ready per cycle up to one cycle past rsp_valid.
    task automatic drive_scan(input bit ir, input int len, input logic [32:0] d);
        last_wait = 0;
        while (!cmd_ready && last_wait < 100) begin
            @(negedge TCLK);
            last_wait++;
        end
        if (!cmd_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: cmd_ready=%b, need 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_ir    = ir;
        cmd_len   = len[5:0];
        cmd_data  = d;
        n_cyc     = 0;
        rv_cnt    = 0;
        rsp_snap  = '0;
        @(negedge TCLK);
        cmd_valid = 1'b0;
        for (int j = 1; j < 60; j++) begin
            tr_tms[j] = TMS;
            tr_wsi[j] = WSI;
            tr_rdy[j] = cmd_ready;
            if (rsp_valid) begin
                rv_cnt++;
                if (n_cyc == 0) begin
                    n_cyc    = j;
                    rsp_snap = rsp_data;
                end
            end
            if (n_cyc != 0 && j == n_cyc + 1) break;
            @(negedge TCLK);
        end
    endtask

    task automatic test_reset;
        int tm = 0, rm = 0;
        TRESETN = 1'b0;
        repeat (2) @(negedge TCLK);
        total++;
        if (TMS !== RST_TMS || WSI !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 33'd0) begin
            bad++;
            $display("FAIL reset_outputs: TMS=%b WSI=%b rsp_valid=%b rsp_data=%h, need %b 0 0 0",
                     TMS, WSI, rsp_valid, rsp_data, RST_TMS);
        end
        total++;
        if (cmd_ready !== RST_RDY) begin
            bad++;
            $display("FAIL reset_ready: cmd_ready=%b, need %b", cmd_ready, RST_RDY);
        end
        TRESETN = 1'b1;
`ifdef STAC_DRV_TLR_INIT_EN
        for (int j = 1; j <= 7; j++) begin
            if (TMS !== (j <= 5)) tm++;
            if (cmd_ready !== (j == 7)) rm++;
            if (j < 7) @(negedge TCLK);
        end
        total++;
        if (tm != 0) begin
            bad++;
            $display("FAIL init_tms: %0d of cycles 1-7 differ from 1,1,1,1,1,0,0, need 0", tm);
        end
        total++;
        if (rm != 0) begin
            bad++;
            $display("FAIL init_ready: %0d of cycles 1-7 wrong, need cmd_ready only in cycle 7", rm);
        end
`else
        total++;
        if (cmd_ready !== 1'b1 || TMS !== 1'b0) begin
            bad++;
            $display("FAIL first_cycle: cmd_ready=%b TMS=%b, need 1 0", cmd_ready, TMS);
        end
`endif
        repeat (2) @(negedge TCLK);
    endtask

    task automatic test_ir_scan;
        int tm = 0, wm = 0;
        drive_scan(1'b1, 8, 33'hA5);
        for (int j = 1; j <= 15; j++) begin
            if (tr_tms[j] !== exp_tms(1'b1, 8, j)) tm++;
            if (tr_wsi[j] !== exp_wsi(1'b1, 8, 33'hA5, j)) wm++;
        end
        total++;
        if (tm != 0 || wm != 0) begin
            bad++;
            $display("FAIL ir_seq: %0d TMS and %0d WSI cycles differ, need 0 0", tm, wm);
        end
        total++;
        if (n_cyc != 14 || rsp_snap !== 33'h0CA) begin
            bad++;
            $display("FAIL ir_rsp: cycle=%0d data=%h, need 14 0ca", n_cyc, rsp_snap);
        end
        total++;
        if (ir_upd !== 8'hA5) begin
            bad++;
            $display("FAIL ir_model: IR=%h, need a5", ir_upd);
        end
    endtask

    task automatic test_dr_scan;
        int tm = 0;
        drive_scan(1'b0, 33, 33'h1_2345_6789);
        for (int j = 1; j <= 39; j++)
            if (tr_tms[j] !== exp_tms(1'b0, 33, j)) tm++;
        total++;
        if (tm != 0) begin
            bad++;
            $display("FAIL dr_tms: %0d cycles differ, need 0", tm);
        end
        total++;
        if (n_cyc != 38 || rsp_snap !== 33'h0CA) begin
            bad++;
            $display("FAIL dr_rsp: cycle=%0d data=%h, need 38 0ca", n_cyc, rsp_snap);
        end
        total++;
        if (dr_upd !== 33'h1_2345_6789) begin
            bad++;
            $display("FAIL dr_model: DR=%h, need 123456789", dr_upd);
        end
    endtask

    task automatic test_zero_len;
        logic [32:0] old = dr_upd;
        drive_scan(1'b0, 0, 33'h1_FFFF_FFFF);
        total++;
        if (n_cyc != 1 || rsp_snap !== 33'd0) begin
            bad++;
            $display("FAIL zero_rsp: cycle=%0d data=%h, need 1 0", n_cyc, rsp_snap);
        end
        total++;
        if (tr_tms[1] !== 1'b0 || tr_tms[2] !== 1'b0 || tr_rdy[2] !== 1'b1 || dr_upd !== old) begin
            bad++;
            $display("FAIL zero_quiet: TMS=%b,%b ready=%b DR=%h, need 0,0 1 %h",
                     tr_tms[1], tr_tms[2], tr_rdy[2], dr_upd, old);
        end
    endtask

    task automatic test_clamp;
        int wm = 0;
        logic [32:0] d = 33'h0_DEAD_BEEF;
        drive_scan(1'b0, 40, d);
        for (int j = 1; j <= 39; j++)
            if (tr_wsi[j] !== exp_wsi(1'b0, 33, d, j)) wm++;
        total++;
        if (n_cyc != 38 || wm != 0) begin
            bad++;
            $display("FAIL clamp_len: cycle=%0d wsi_diffs=%0d, need 38 0", n_cyc, wm);
        end
        total++;
        if (dr_upd !== d || rsp_snap !== 33'h0CA) begin
            bad++;
            $display("FAIL clamp_data: DR=%h rsp=%h, need %h 0ca", dr_upd, rsp_snap, d);
        end
    endtask

    task automatic test_back_to_back;
        logic [32:0] a = 33'h0_0000_0013, b = 33'h0_0000_0055;
        drive_scan(1'b1, 5, a);
        total++;
        if (n_cyc != 11 || tr_rdy[12] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first: cycle=%0d ready_after=%b, need 11 1", n_cyc, tr_rdy[12]);
        end
        drive_scan(1'b0, 7, b);
        total++;
        if (last_wait != 0) begin
            bad++;
            $display("FAIL b2b_wait: waited %0d cycles, need 0", last_wait);
        end
        total++;
        if (n_cyc != 12 || rsp_snap !== exp_rsp(1'b0, 7, b)) begin
            bad++;
            $display("FAIL b2b_second: cycle=%0d data=%h, need 12 %h", n_cyc, rsp_snap, exp_rsp(1'b0, 7, b));
        end
        total++;
        if ({25'd0, ir_upd} !== exp_upd(1'b1, 5, a, 33'd0)) begin
            bad++;
            $display("FAIL b2b_ir: IR=%h, need %h", ir_upd, exp_upd(1'b1, 5, a, 33'd0));
        end
    endtask

    task automatic test_busy;
        int w = 0, rv = 0, first = 0;
        logic [32:0] a = 33'h1_0F0F_0ABC;
        while (!cmd_ready && w < 100) begin
            @(negedge TCLK);
            w++;
        end
        cmd_valid = 1'b1;
        cmd_ir    = 1'b0;
        cmd_len   = 6'd12;
        cmd_data  = a;
        @(negedge TCLK);
        cmd_data = 33'h0_1234_0000;
        cmd_len  = 6'd20;
        for (int j = 1; j <= 30; j++) begin
            if (j == 15) cmd_valid = 1'b0;
            if (rsp_valid) begin
                rv++;
                if (first == 0) first = j;
            end
            @(negedge TCLK);
        end
        total++;
        if (first != 17 || rv != 1) begin
            bad++;
            $display("FAIL busy_rsp: first=%0d pulses=%0d, need 17 1", first, rv);
        end
        total++;
        if (dr_upd !== exp_upd(1'b0, 12, a, 33'd0)) begin
            bad++;
            $display("FAIL busy_model: DR=%h, need %h", dr_upd, exp_upd(1'b0, 12, a, 33'd0));
        end
    endtask

    task automatic test_reset_mid;
        int w = 0, rv = 0;
        logic [32:0] d;
        while (!cmd_ready && w < 100) begin
            @(negedge TCLK);
            w++;
        end
        cmd_valid = 1'b1;
        cmd_ir    = 1'b0;
        cmd_len   = 6'd33;
        cmd_data  = '1;
        @(negedge TCLK);
        cmd_valid = 1'b0;
        repeat (13) @(negedge TCLK);
        total++;
        if (TMS !== 1'b0 || WSI !== 1'b1 || rsp_data !== 33'h0CA) begin
            bad++;
            $display("FAIL mid_before: TMS=%b WSI=%b rsp=%h, need 0 1 0ca", TMS, WSI, rsp_data);
        end
        TRESETN = 1'b0;
        #1;
        total++;
        if (TMS !== RST_TMS || WSI !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== RST_RDY || rsp_data !== 33'd0) begin
            bad++;
            $display("FAIL mid_reset: TMS=%b WSI=%b rv=%b ready=%b rsp=%h, need %b 0 0 %b 0",
                     TMS, WSI, rsp_valid, cmd_ready, rsp_data, RST_TMS, RST_RDY);
        end
        repeat (2) @(negedge TCLK);
        TRESETN = 1'b1;
        for (int j = 0; j < 50; j++) begin
            @(negedge TCLK);
            if (rsp_valid) rv++;
        end
        total++;
        if (rv != 0) begin
            bad++;
            $display("FAIL mid_no_rsp: %0d pulses, need 0", rv);
        end
        d = 33'({$urandom(), $urandom()});
        drive_scan(1'b0, 33, d);
        total++;
        if (n_cyc != 38 || rsp_snap !== 33'h0CA || dr_upd !== d) begin
            bad++;
            $display("FAIL mid_recover: cycle=%0d rsp=%h DR=%h, need 38 0ca %h", n_cyc, rsp_snap, dr_upd, d);
        end
    endtask

    task automatic test_random;
        bit          ir;
        int          len, L, n, tm, wm, rm;
        logic [32:0] d, old, upd;
        for (int i = 0; i < 20; i++) begin
            ir  = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 40);
            d   = 33'({$urandom(), $urandom()});
            L   = eff(len);
            n   = exp_n(ir, L);
            old = ir ? {25'd0, ir_upd} : dr_upd;
            tm  = 0;
            wm  = 0;
            rm  = 0;
            drive_scan(ir, len, d);
            for (int j = 1; j <= n + 1; j++) begin
                if (tr_tms[j] !== exp_tms(ir, L, j)) tm++;
                if (tr_wsi[j] !== exp_wsi(ir, L, d, j)) wm++;
                if (tr_rdy[j] !== (j == n + 1)) rm++;
            end
            upd = ir ? {25'd0, ir_upd} : dr_upd;
            total++;
            if (tm != 0 || wm != 0 || rm != 0) begin
                bad++;
                $display("FAIL rand%0d_seq: ir=%0d len=%0d tms/wsi/ready diffs=%0d/%0d/%0d, need 0/0/0",
                         i, ir, len, tm, wm, rm);
            end
            total++;
            if (n_cyc != n || rv_cnt != 1) begin
                bad++;
                $display("FAIL rand%0d_timing: ir=%0d len=%0d cycle=%0d pulses=%0d, need %0d 1",
                         i, ir, len, n_cyc, rv_cnt, n);
            end
            total++;
            if (rsp_snap !== exp_rsp(ir, L, d)) begin
                bad++;
                $display("FAIL rand%0d_rsp: ir=%0d len=%0d rsp=%h, need %h", i, ir, len, rsp_snap, exp_rsp(ir, L, d));
            end
            total++;
            if (upd !== exp_upd(ir, L, d, old)) begin
                bad++;
                $display("FAIL rand%0d_model: ir=%0d len=%0d reg=%h, need %h", i, ir, len, upd, exp_upd(ir, L, d, old));
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ir_scan();
        test_dr_scan();
        test_zero_len();
        test_clamp();
        test_back_to_back();
        test_busy();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stac_scan_driver.md
# stac_scan_driver

Tester-side scan sequencer that sits directly upstream of the STAC test-access wrapper and drives its TMS/WSI pins while capturing WSO. It accepts one IR-scan or DR-scan command at a time over a valid/ready interface and walks the wrapper's TAP state machine from Run-Test/Idle through Capture/Shift/Exit1/Update and back. It shifts up to MAX_LEN bits LSB-first and returns the captured WSO bits as a one-cycle response.

## Interface
- MAX_LEN, 33, maximum scan length in bits; covers the 33-bit TDRs and the 8-bit IR.
- LEN_W, 6, width of the length field; must satisfy 2^LEN_W > MAX_LEN.

- TCLK  in  1  scan clock; all state updates on the rising edge.
- TRESETN  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  driver idle and able to accept a command.
- cmd_ir  in  1  1 = IR scan, 0 = DR scan.
- cmd_len  in  LEN_W  number of bits to shift.
- cmd_data  in  MAX_LEN  shift-in data; bit 0 is shifted first.
- rsp_valid  out  1  one-cycle pulse: scan complete.
- rsp_data  out  MAX_LEN  captured WSO bits; bit i is the WSO sample of shift cycle i.
- TMS  out  1  to the wrapper's TMS pin; registered.
- WSI  out  1  to the wrapper's WSI pin; registered.
- WSO  in  1  from the wrapper's WSO pin.

## Operation
- States: INIT, IDLE, SEL_IR, SEL, CAPTURE, SHIFT, EXIT1, UPDATE, DONE.
- The handshake completes on a rising edge with cmd_valid && cmd_ready. cmd_ready = (state == IDLE).
- On acceptance, latch cmd_ir and cmd_data, and latch the effective length L = min(cmd_len, MAX_LEN). Clear the capture register.
- The TMS sequence per cycle after acceptance is fixed:
  - DR scan: 1 (SEL), 0 (CAPTURE), 0 (transition into Shift), then L shift cycles with TMS=0 except the last, which has TMS=1. Then 1 (UPDATE) and 0 (DONE).
  - IR scan: same sequence with an extra leading 1 (SEL_IR).
- Shift cycle i (0..L-1): WSI = data[i]. WSO is sampled into rsp_data[i] on the rising edge that ends the cycle.
- Outside shift cycles, WSI = 0.
- rsp_data bits at index L and above read 0.
- In DONE, rsp_valid = 1 for exactly one cycle, then the driver returns to IDLE.
- rsp_data holds its value until the next command is accepted. There is no response backpressure.
- L = 0: the command is accepted, no TAP traffic is generated (TMS stays 0), and rsp_valid pulses in the next cycle with rsp_data = 0.
- cmd_len > MAX_LEN is clamped to MAX_LEN.
- cmd_valid while busy is ignored; the command is held off by cmd_ready = 0.
- Reset mid-scan: all state aborts immediately to the reset values. A partial response is never signalled.

## Timing
- Reset values:
  - TMS = 1 with STAC_DRV_TLR_INIT_EN, 0 without.
  - WSI = 0, rsp_valid = 0, rsp_data = 0.
  - cmd_ready = 0 with STAC_DRV_TLR_INIT_EN, 1 without.
- Acceptance at edge k. TMS/WSI for sequence cycle j are valid from edge k+j-1 through edge k+j.
- DR scan: L+5 cycles; rsp_valid in cycle L+5, cmd_ready high in cycle L+6.
- IR scan: L+6 cycles; rsp_valid in cycle L+6, cmd_ready high in cycle L+7.
- Back-to-back throughput: a new command can be accepted on the first cycle cmd_ready is high. No idle TMS=0 padding is required beyond DONE.

## Configuration
- STAC_DRV_TLR_INIT_EN defined:
  - After TRESETN deasserts, INIT drives TMS=1 for 5 cycles, then TMS=0 for 1 cycle. This forces the TAP to Test-Logic-Reset and then Run-Test/Idle.
  - cmd_ready first rises in cycle 7.
- Undefined:
  - INIT is omitted; reset goes straight to IDLE with TMS=0.
  - The TAP is relied on to be reset by the shared TRESETN.

## Test plan
- Bench TAP model: 8-bit IR, DR loopback, capture value 33'h0CA.
- Reset, macro defined -> TMS=1,1,1,1,1,0 on cycles 1-6; cmd_ready=1 from cycle 7. Macro undefined -> cmd_ready=1 on the first cycle after reset.
- IR scan, len 8, data 8'hA5 -> TMS sequence 1,1,0,0, 0×7, 1, 1, 0. WSI shift bits 1,0,1,0,0,1,0,1. rsp_valid in cycle 14; model IR = 8'hA5.
- DR scan, len 33, data 33'h1_2345_6789 -> rsp_data = 33'h0CA. rsp_valid in cycle 38. Model update register = 33'h1_2345_6789.
- cmd_len=0 -> rsp_valid the cycle after acceptance with rsp_data=0. TMS stays 0 throughout.
- cmd_len=40 -> clamped to 33 shift cycles; rsp_valid in cycle 38.
- TRESETN asserted in shift cycle 10 of a 33-bit DR scan -> TMS, WSI, rsp_valid and cmd_ready take their reset values immediately. No rsp_valid pulse. A subsequent scan completes correctly.
